// File: rtl/bus_dma_master_if.sv
// Bus master port bundle for the copy engine.
// Master drives request/address/data, slave answers grant/read data.
interface bus_dma_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) ();
  logic              m_req;
  logic              m_grant;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_din;

  modport master (
    output m_req,
    output m_wr,
    output m_addr,
    output m_dout,
    input  m_grant,
    input  m_din
  );

  modport slave (
    input  m_req,
    input  m_wr,
    input  m_addr,
    input  m_dout,
    output m_grant,
    output m_din
  );
endinterface

// File: rtl/bus_dma_master.sv
// Single-channel block copy engine: read word, write word, repeat.
// Holds the bus from first grant until the last write completes.
module bus_dma_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  bus_dma_master_if.master    m
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_CAP,
    S_WR,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic go;
  logic go_empty;
  logic last;

  assign go       = start && (len != '0);
  assign go_empty = start && (len == '0);
  assign last     = (cnt_q == LEN_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; every bus phase waits for grant
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (go)            state_d = S_WAIT;
        else if (go_empty) state_d = S_FIN;
      end
      S_WAIT: if (m.m_grant) state_d = S_RD;
      S_RD:   if (m.m_grant) state_d = S_CAP;
      S_CAP:  if (m.m_grant) state_d = S_WR;
      S_WR: begin
        if (m.m_grant) state_d = last ? S_FIN : S_RD;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and the latched pointers/buffer
  always_comb begin
    m.m_req  = 1'b0;
    m.m_wr   = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    m.m_addr = src_q;
    m.m_dout = buf_q;
    unique case (state_q)
      S_WAIT, S_RD, S_CAP: m.m_req = 1'b1;
      S_WR: begin
        m.m_req  = 1'b1;
        m.m_wr   = 1'b1;
        m.m_addr = dst_q;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: latch on start, capture read, advance on write
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    unique case (1'b1)
      (state_q == S_IDLE) && go: begin
        src_d = src_addr;
        dst_d = dst_addr;
        cnt_d = len;
      end
      (state_q == S_CAP) && m.m_grant: begin
        buf_d = m.m_din;
      end
      (state_q == S_WR) && m.m_grant: begin
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        cnt_d = cnt_q - LEN_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master with a one-cycle-latency slave.
// Grant is shaped per run to insert request and write stalls.
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;

  bus_dma_master_if #(.ADDR_W(16), .DATA_W(64)) bus ();

  bus_dma_master #(
    .ADDR_W(16),
    .DATA_W(64),
    .LEN_W (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .m       (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sdata(input logic [15:0] a);
    case (a)
      16'h0010: sdata = 64'hAA;
      16'h0011: sdata = 64'hBB;
      default:  sdata = {16'hD00D, 32'h0, a};
    endcase
  endfunction

  logic [15:0] wa_q[$];
  logic [63:0] wd_q[$];

  // Slave: read data one cycle after a granted read, log granted writes
  always @(posedge clk) begin
    if (reset) begin
      bus.m_din <= '0;
    end else if (bus.m_req && bus.m_grant) begin
      if (bus.m_wr) begin
        wa_q.push_back(bus.m_addr);
        wd_q.push_back(bus.m_dout);
      end else begin
        bus.m_din <= sdata(bus.m_addr);
      end
    end
  end

  task automatic run_copy(input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] l, input int wg,
                          input int wst, input int restart_at,
                          input string tag);
    int          exp_done;
    int          base;
    int          k;
    int          done_at;
    int          wgc;
    int          wrc;
    bit          first_gnt;
    bit          viol_wr;
    bit          viol_drop;
    bit          viol_frz;
    bit          req_seen;
    bit          frz_valid;
    logic        prev_req;
    logic [15:0] fa;
    logic [63:0] fd;
    logic [15:0] ea;
    exp_done  = (l == 8'd0) ? 1 : 2 + 3 * int'(l) + wg + wst;
    base      = wa_q.size();
    k         = 0;
    done_at   = -1;
    wgc       = wg;
    wrc       = wst;
    first_gnt = 1'b0;
    viol_wr   = 1'b0;
    viol_drop = 1'b0;
    viol_frz  = 1'b0;
    req_seen  = 1'b0;
    frz_valid = 1'b0;
    prev_req  = 1'b0;
    fa        = '0;
    fd        = '0;
    @(negedge clk);
    src_addr    = s;
    dst_addr    = d;
    len         = l;
    start       = 1'b1;
    bus.m_grant = 1'b0;
    while (done_at < 0 && k < 300) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
      end
      if (k == restart_at) begin
        start    = 1'b1;
        src_addr = 16'h1234;
        dst_addr = 16'h4321;
        len      = 8'd5;
      end else if (k == restart_at + 1) begin
        start = 1'b0;
      end
      if (bus.m_req) req_seen = 1'b1;
      if (bus.m_wr && !bus.m_req) viol_wr = 1'b1;
      if (done && (bus.m_req || bus.m_wr)) viol_wr = 1'b1;
      if (prev_req && !bus.m_req && !done) viol_drop = 1'b1;
      if (done) done_at = k;
      if (bus.m_req && !first_gnt) begin
        if (wgc > 0) begin
          bus.m_grant = 1'b0;
          wgc--;
        end else begin
          bus.m_grant = 1'b1;
          first_gnt   = 1'b1;
        end
      end else if (bus.m_wr && wrc > 0) begin
        bus.m_grant = 1'b0;
        if (!frz_valid) begin
          fa        = bus.m_addr;
          fd        = bus.m_dout;
          frz_valid = 1'b1;
        end else if (bus.m_addr !== fa || bus.m_dout !== fd) begin
          viol_frz = 1'b1;
        end
        wrc--;
      end else begin
        if (frz_valid && bus.m_wr) begin
          if (bus.m_addr !== fa || bus.m_dout !== fd) viol_frz = 1'b1;
          frz_valid = 1'b0;
        end
        bus.m_grant = bus.m_req;
      end
      prev_req = bus.m_req;
    end
    bus.m_grant = 1'b0;
    chk({tag, "_done_cyc"}, 64'(done_at), 64'(exp_done));
    chk({tag, "_wr_scope"}, 64'(viol_wr), 64'd0);
    chk({tag, "_req_hold"}, 64'(viol_drop), 64'd0);
    if (wst > 0) chk({tag, "_frozen"}, 64'(viol_frz), 64'd0);
    if (l == 8'd0) chk({tag, "_no_req"}, 64'(req_seen), 64'd0);
    chk({tag, "_nwr"}, 64'(wa_q.size() - base), 64'(l));
    for (int i = 0; i < int'(l); i++) begin
      if (base + i < wa_q.size()) begin
        ea = d + 16'(i);
        chk($sformatf("%s_wa%0d", tag, i), 64'(wa_q[base+i]), 64'(ea));
        ea = s + 16'(i);
        chk($sformatf("%s_wd%0d", tag, i), wd_q[base+i], sdata(ea));
      end
    end
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit          seen;
    bit          hit_wr;
    reset       = 1'b1;
    start       = 1'b1;
    src_addr    = 16'h5555;
    dst_addr    = 16'hAAAA;
    len         = 8'd3;
    bus.m_grant = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(bus.m_req), 64'd0);
    chk("rst_wr", 64'(bus.m_wr), 64'd0);
    chk("rst_addr", 64'(bus.m_addr), 64'd0);
    chk("rst_dout", bus.m_dout, 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_req", 64'(bus.m_req), 64'd0);

    run_copy(16'h0010, 16'h7000, 8'd2, 0, 0, 0, "basic");
    run_copy(16'h0010, 16'h7000, 8'd2, 3, 2, 0, "stall");
    run_copy(16'h0040, 16'h7400, 8'd0, 0, 0, 0, "len0");
    run_copy(16'h0020, 16'h7100, 8'd2, 0, 0, 3, "restart");
    run_copy(16'hFFFF, 16'h7001, 8'd2, 0, 0, 0, "wrap");

    @(negedge clk);
    src_addr = 16'h0100;
    dst_addr = 16'h0200;
    len      = 8'd4;
    start    = 1'b1;
    hit_wr   = 1'b0;
    for (int k = 0; k < 50 && !hit_wr; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.m_wr) begin
        hit_wr      = 1'b1;
        bus.m_grant = 1'b0;
        reset       = 1'b1;
      end else begin
        bus.m_grant = bus.m_req;
      end
    end
    chk("mid_hit_wr", 64'(hit_wr), 64'd1);
    @(negedge clk);
    chk("mid_req", 64'(bus.m_req), 64'd0);
    chk("mid_wr", 64'(bus.m_wr), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || bus.m_req) seen = 1'b1;
    end
    chk("mid_quiet", 64'(seen), 64'd0);
    run_copy(16'h0300, 16'h0400, 8'd1, 0, 0, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
